// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares the single RAM port between NUM_REQ requesters using round-robin
// arbitration. A grant is held for a whole transaction: either one word, or a
// BLOCK_WORDS burst whose word addresses are generated here by stepping the
// requester's base address by WORD_BYTES per word.
//
// Ports
//   CLK       clock
//   nRST      asynchronous active-low reset
//   req       per-requester request, held high until the transaction ends
//   wen       per-requester write(1)/read(0), sampled at grant
//   burst     per-requester burst(1)/single(0), sampled at grant
//   addr      per-requester base address, slice i = [32*i+31:32*i]
//   store     per-requester write data for the current word
//   ramstate  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   ramload   RAM read data
//   ramaddr   RAM address (0 outside a transfer)
//   ramstore  RAM write data (0 outside a transfer)
//   ramREN    RAM read enable
//   ramWEN    RAM write enable
//   rwait     per-requester wait, low only on the cycle a word completes
//   rload     ramload broadcast to all requesters
//   rerr      per-requester one-cycle error pulse
//   grant     one-hot current owner, 0 when no transfer is in progress
//   word_idx  current burst word index, 0 outside a transfer
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int BLOCK_WORDS = 2,
  parameter int WORD_BYTES  = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          wen,
  input  logic [NUM_REQ-1:0]          burst,
  input  logic [NUM_REQ*32-1:0]       addr,
  input  logic [NUM_REQ*32-1:0]       store,
  input  logic [1:0]                  ramstate,
  input  logic [31:0]                 ramload,
  output logic [31:0]                 ramaddr,
  output logic [31:0]                 ramstore,
  output logic                        ramREN,
  output logic                        ramWEN,
  output logic [NUM_REQ-1:0]          rwait,
  output logic [31:0]                 rload,
  output logic [NUM_REQ-1:0]          rerr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(BLOCK_WORDS):0] word_idx
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(BLOCK_WORDS) + 1;

  // Only the two ramstate codes that change behaviour are named; FREE and
  // BUSY both simply hold the current word.
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;

  logic [IDXW-1:0]     ptr_r;
  logic [IDXW-1:0]     owner_r;
  logic [NUM_REQ-1:0]  grant_r;
  logic                wen_q_r;
  logic [CNTW-1:0]     last_idx_r;
  logic [CNTW-1:0]     word_cnt_r;

  logic [IDXW-1:0]     pick_s;
  logic                pick_valid_s;
  logic [NUM_REQ-1:0]  pick_oh_s;

  logic                owner_req_s;
  logic [31:0]         owner_addr_s;
  logic [31:0]         owner_store_s;
  logic [31:0]         word_offset_s;
  logic                last_word_s;
  logic                xfer_end_s;
  logic [IDXW-1:0]     next_ptr_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = (idx == IDXW'(i));
    end
    return v;
  endfunction

  // Round-robin pick: lowest requesting index at or above the pointer,
  // otherwise (wrap-around) the lowest requesting index overall.
  always_comb begin
    logic            hi_valid;
    logic [IDXW-1:0] hi_idx;
    logic            lo_valid;
    logic [IDXW-1:0] lo_idx;
    logic            hit;
    hi_valid = 1'b0;
    hi_idx   = {IDXW{1'b0}};
    lo_valid = 1'b0;
    lo_idx   = {IDXW{1'b0}};
    hit      = 1'b0;
    // Scanning downwards leaves the lowest matching index in each candidate.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      hit      = req[i] & (IDXW'(i) >= ptr_r);
      hi_idx   = hit ? IDXW'(i) : hi_idx;
      hi_valid = hi_valid | hit;
      lo_idx   = req[i] ? IDXW'(i) : lo_idx;
      lo_valid = lo_valid | req[i];
    end
    pick_s       = hi_valid ? hi_idx : lo_idx;
    pick_valid_s = lo_valid;
    pick_oh_s    = onehot(pick_s);
  end

  // Owner-side view: the owner's request, base address and store data, plus
  // the burst address offset and end-of-transfer detection.
  always_comb begin
    owner_addr_s  = 32'd0;
    owner_store_s = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_addr_s  = (owner_r == IDXW'(i)) ? addr[32*i +: 32]  : owner_addr_s;
      owner_store_s = (owner_r == IDXW'(i)) ? store[32*i +: 32] : owner_store_s;
    end
    // grant_r is one-hot on the owner for the whole transfer.
    owner_req_s   = |(req & grant_r);
    word_offset_s = 32'(WORD_BYTES) * 32'(word_cnt_r);
    last_word_s   = (word_cnt_r == last_idx_r);
    if (state_r == ST_XFER) begin
      xfer_end_s = ~owner_req_s
                 | (ramstate == RAM_ERROR)
                 | ((ramstate == RAM_ACCESS) & last_word_s);
    end else begin
      xfer_end_s = 1'b0;
    end
    if (owner_r == IDXW'(NUM_REQ - 1)) begin
      next_ptr_s = {IDXW{1'b0}};
    end else begin
      next_ptr_s = owner_r + IDXW'(1);
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. A dropped request returns straight to IDLE; a normal
  // completion or an error passes through RELEASE so the owner can drop req.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_next_s = ST_XFER;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (!owner_req_s) begin
          state_next_s = ST_IDLE;
        end else if (xfer_end_s) begin
          state_next_s = ST_RELEASE;
        end else begin
          state_next_s = ST_XFER;
        end
      end
      ST_RELEASE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Transaction registers: owner, attributes captured at grant, word counter
  // and the round-robin pointer, which moves past the owner when it finishes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_r      <= {IDXW{1'b0}};
      owner_r    <= {IDXW{1'b0}};
      grant_r    <= {NUM_REQ{1'b0}};
      wen_q_r    <= 1'b0;
      last_idx_r <= {CNTW{1'b0}};
      word_cnt_r <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            owner_r    <= pick_s;
            grant_r    <= pick_oh_s;
            wen_q_r    <= |(wen & pick_oh_s);
            last_idx_r <= (|(burst & pick_oh_s)) ? CNTW'(BLOCK_WORDS - 1) : {CNTW{1'b0}};
            word_cnt_r <= {CNTW{1'b0}};
          end else begin
            grant_r    <= {NUM_REQ{1'b0}};
          end
        end
        ST_XFER: begin
          if (xfer_end_s) begin
            grant_r    <= {NUM_REQ{1'b0}};
            word_cnt_r <= {CNTW{1'b0}};
            ptr_r      <= next_ptr_s;
          end else if (ramstate == RAM_ACCESS) begin
            word_cnt_r <= word_cnt_r + CNTW'(1);
          end else begin
            word_cnt_r <= word_cnt_r;
          end
        end
        default: begin
          grant_r    <= {NUM_REQ{1'b0}};
          word_cnt_r <= {CNTW{1'b0}};
        end
      endcase
    end
  end

  // Output logic. Enables follow the owner's req combinationally so a
  // withdrawn request stops the RAM access in the same cycle.
  always_comb begin
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    rwait    = {NUM_REQ{1'b1}};
    rerr     = {NUM_REQ{1'b0}};
    word_idx = {CNTW{1'b0}};
    if (state_r == ST_XFER) begin
      ramaddr  = owner_addr_s + word_offset_s;
      ramstore = owner_store_s;
      ramWEN   = wen_q_r & owner_req_s;
      ramREN   = ~wen_q_r & owner_req_s;
      word_idx = word_cnt_r;
      if (owner_req_s) begin
        case (ramstate)
          RAM_ACCESS: rwait = ~grant_r;
          RAM_ERROR:  rerr  = grant_r;
          default:    rwait = {NUM_REQ{1'b1}};
        endcase
      end else begin
        rwait = {NUM_REQ{1'b1}};
      end
    end else begin
      ramaddr  = 32'd0;
      ramstore = 32'd0;
    end
  end

  assign rload = ramload;
  assign grant = grant_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter (NUM_REQ=2, BLOCK_WORDS=2,
// WORD_BYTES=4). The stimulus process queues the expected word completions
// and error pulses; a monitor compares each one when the DUT presents it.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic [1:0]  req;
  logic [1:0]  wen;
  logic [1:0]  burst;
  logic [63:0] addr;
  logic [63:0] store;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ramREN;
  logic        ramWEN;
  logic [1:0]  rwait;
  logic [31:0] rload;
  logic [1:0]  rerr;
  logic [1:0]  grant;
  logic [1:0]  word_idx;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          who;
    logic        is_err;
    logic [31:0] a;
    logic        wr;
    logic [1:0]  widx;
    logic [31:0] d;
  } exp_t;

  exp_t sb_q[$];

  ram_port_arbiter #(
    .NUM_REQ(2), .BLOCK_WORDS(2), .WORD_BYTES(4)
  ) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .burst(burst),
    .addr(addr), .store(store), .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .rwait(rwait), .rload(rload), .rerr(rerr), .grant(grant), .word_idx(word_idx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int who, input logic is_err, input logic [31:0] a,
                      input logic wr, input logic [1:0] widx, input logic [31:0] d);
    exp_t e;
    e.who = who; e.is_err = is_err; e.a = a; e.wr = wr; e.widx = widx; e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic to_pos;
    @(posedge CLK);
    #1;
  endtask

  task automatic to_neg;
    @(negedge CLK);
  endtask

  // Monitor: every completed word (rwait low) or error pulse pops one entry.
  always @(negedge CLK) begin
    if (nRST && ((rwait != 2'b11) || (rerr != 2'b00))) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: rwait=%b rerr=%b with nothing expected at %0t", rwait, rerr, $time);
      end else begin
        exp_t e;
        logic [31:0] oh;
        e  = sb_q.pop_front();
        oh = 32'h1 << e.who;
        check("sb_rwait", {30'd0, rwait}, e.is_err ? 32'h3 : (32'h3 & ~oh));
        check("sb_rerr", {30'd0, rerr}, e.is_err ? oh : 32'h0);
        check("sb_grant", {30'd0, grant}, oh);
        check("sb_ramaddr", ramaddr, e.a);
        check("sb_ramWEN", {31'd0, ramWEN}, {31'd0, e.wr});
        check("sb_ramREN", {31'd0, ramREN}, {31'd0, ~e.wr});
        check("sb_word_idx", {30'd0, word_idx}, {30'd0, e.widx});
        if (e.wr) begin
          check("sb_ramstore", ramstore, e.d);
        end else begin
          check("sb_rload", rload, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; req = 2'b11; wen = 2'b00; burst = 2'b00;
    addr = 64'd0; store = 64'd0; ramstate = FREE; ramload = 32'd0;

    // Reset held with both requesting.
    repeat (2) begin
      to_neg;
      check("rst_ramREN", {31'd0, ramREN}, 32'd0);
      check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_rwait", {30'd0, rwait}, 32'd3);
      check("rst_ramaddr", ramaddr, 32'd0);
    end
    to_pos; nRST = 1'b1;
    to_neg; check("grant_latency_idle", {30'd0, grant}, 32'd0);
    to_pos;
    to_neg; check("grant_after_reset", {30'd0, grant}, 32'd1);
    check("ren_after_reset", {31'd0, ramREN}, 32'd1);
    // Reset in the middle of a transfer clears everything at once.
    #1 nRST = 1'b0; req = 2'b00;
    #1;
    check("async_rst_grant", {30'd0, grant}, 32'd0);
    check("async_rst_ramREN", {31'd0, ramREN}, 32'd0);
    to_pos; nRST = 1'b1;

    // Requester 0 single read, ACCESS on the 3rd XFER cycle.
    addr[31:0] = 32'h100; ramload = 32'hCAFE_0100; ramstate = FREE; req = 2'b01;
    push(0, 1'b0, 32'h100, 1'b0, 2'd0, 32'hCAFE_0100);
    to_neg; check("rd_idle_ren", {31'd0, ramREN}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      to_pos; ramstate = (k == 2) ? ACCESS : BUSY;
      to_neg;
      check("rd_ren", {31'd0, ramREN}, 32'd1);
      check("rd_addr", ramaddr, 32'h100);
      if (k < 2) check("rd_wait_hold", {30'd0, rwait}, 32'd3);
    end
    to_pos; req = 2'b00; ramstate = FREE;
    to_neg;
    check("rd_release_ren", {31'd0, ramREN}, 32'd0);
    check("rd_release_grant", {30'd0, grant}, 32'd0);
    check("rd_release_rwait", {30'd0, rwait}, 32'd3);
    to_pos; to_neg;

    // Requester 1 burst write, ACCESS every cycle.
    to_pos;
    req = 2'b10; wen = 2'b10; burst = 2'b10; addr[63:32] = 32'h200;
    store[63:32] = 32'h5555_0000; ramstate = ACCESS; ramload = 32'd0;
    push(1, 1'b0, 32'h200, 1'b1, 2'd0, 32'h5555_0000);
    push(1, 1'b0, 32'h204, 1'b1, 2'd1, 32'h5555_0001);
    to_neg; check("wr_idle_wen", {31'd0, ramWEN}, 32'd0);
    to_pos;
    to_neg; check("wr_w0_wen", {31'd0, ramWEN}, 32'd1);
    check("wr_w0_addr", ramaddr, 32'h200);
    to_pos; store[63:32] = 32'h5555_0001;
    to_neg; check("wr_w1_wen", {31'd0, ramWEN}, 32'd1);
    check("wr_w1_idx", {30'd0, word_idx}, 32'd1);
    to_pos; req = 2'b00; wen = 2'b00; burst = 2'b00;
    to_neg; check("wr_release_wen", {31'd0, ramWEN}, 32'd0);
    check("wr_release_idx", {30'd0, word_idx}, 32'd0);
    to_pos; to_neg;

    // Both requesting single reads: strict alternation, 3 cycles per grant.
    to_pos;
    req = 2'b11; addr[31:0] = 32'h300; addr[63:32] = 32'h400;
    ramstate = ACCESS; ramload = 32'h1234_5678;
    for (int t = 0; t < 8; t++) begin
      push(t % 2, 1'b0, (t % 2 == 1) ? 32'h400 : 32'h300, 1'b0, 2'd0, 32'h1234_5678);
    end
    for (int c = 0; c < 24; c++) begin
      to_neg;
      check("rr_grant", {30'd0, grant},
            (c % 3 == 1) ? ((((c / 3) % 2) == 1) ? 32'd2 : 32'd1) : 32'd0);
      to_pos;
    end
    req = 2'b00;
    to_neg; check("rr_idle_grant", {30'd0, grant}, 32'd0);

    // ERROR on word 1 of requester 0's burst; requester 1 goes next.
    to_pos;
    req = 2'b11; burst = 2'b01; addr[31:0] = 32'h500; addr[63:32] = 32'h600;
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    push(0, 1'b0, 32'h500, 1'b0, 2'd0, 32'h0BAD_F00D);
    push(0, 1'b1, 32'h504, 1'b0, 2'd1, 32'h0BAD_F00D);
    push(1, 1'b0, 32'h600, 1'b0, 2'd0, 32'h0BAD_F00D);
    to_neg;
    to_pos;
    to_neg; check("err_w0_idx", {30'd0, word_idx}, 32'd0);
    to_pos; ramstate = ERROR;
    to_neg; check("err_w1_addr", ramaddr, 32'h504);
    to_pos; ramstate = ACCESS;
    to_neg;
    check("err_release_ren", {31'd0, ramREN}, 32'd0);
    check("err_release_rerr", {30'd0, rerr}, 32'd0);
    check("err_release_grant", {30'd0, grant}, 32'd0);
    to_pos;
    to_neg; check("err_idle_grant", {30'd0, grant}, 32'd0);
    to_pos;
    to_neg; check("err_next_grant", {30'd0, grant}, 32'd2);
    to_pos; req = 2'b00; burst = 2'b00;
    to_neg;
    to_pos; to_neg;

    // Requester 0 drops req after burst word 0.
    to_pos;
    req = 2'b01; burst = 2'b01; addr[31:0] = 32'h700; ramstate = ACCESS;
    ramload = 32'h7777_0000;
    push(0, 1'b0, 32'h700, 1'b0, 2'd0, 32'h7777_0000);
    to_neg;
    to_pos;
    to_neg; check("drop_w0_ren", {31'd0, ramREN}, 32'd1);
    to_pos; req = 2'b00;
    to_neg;
    check("drop_ren", {31'd0, ramREN}, 32'd0);
    check("drop_rerr", {30'd0, rerr}, 32'd0);
    check("drop_rwait", {30'd0, rwait}, 32'd3);
    to_pos; req = 2'b11; burst = 2'b00; addr[63:32] = 32'h800;
    push(1, 1'b0, 32'h800, 1'b0, 2'd0, 32'h7777_0000);
    to_neg; check("drop_idle_grant", {30'd0, grant}, 32'd0);
    to_pos;
    to_neg; check("drop_ptr_grant", {30'd0, grant}, 32'd2);
    to_pos; req = 2'b00;
    to_neg;
    to_pos; to_neg;

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares the single RAM port between NUM_REQ requesters (per-core icache/dcache ports or coherency-controller request lanes).
- Holds a grant for a whole transaction: a single word, or a BLOCK_WORDS burst whose word addresses it generates itself.
- Drives ramaddr/ramstore/ramREN/ramWEN and returns per-requester wait/load/error.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BLOCK_WORDS, 2, words per burst transaction (power of two, 1..8).
- WORD_BYTES, 4, address increment per burst word.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  request valid, held high until transaction completes.
- wen  input  NUM_REQ  1 = write, 0 = read (sampled at grant).
- burst  input  NUM_REQ  1 = BLOCK_WORDS burst, 0 = single word (sampled at grant).
- addr  input  NUM_REQ*32  base word address per requester, slice i = bits [32*i+31:32*i].
- store  input  NUM_REQ*32  write data per requester, current word presented by requester.
- ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- ramload  input  32  RAM read data.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- rwait  output  NUM_REQ  per-requester wait, low exactly on the cycle a word completes.
- rload  output  32  ramload broadcast; valid for the requester whose rwait is low.
- rerr  output  NUM_REQ  one-cycle error pulse.
- grant  output  NUM_REQ  one-hot current owner, 0 when idle.
- word_idx  output  $clog2(BLOCK_WORDS)+1  current burst word index.

Behaviour:
- Reset: state IDLE, grant=0, priority pointer=0, word counter=0. Outputs ramREN=ramWEN=0, ramaddr=ramstore=0, rwait all 1, rerr=0, rload=ramload.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - Pick the first req bit at or above the pointer, wrapping modulo NUM_REQ.
  - Register grant, wen, burst and word count len = burst ? BLOCK_WORDS : 1.
  - Go to XFER next cycle; ram enables are 0 in IDLE.
  - Grant latency is 1 cycle from req high.
- XFER, owner g:
  - ramaddr = addr[g] + WORD_BYTES*word_cnt (32-bit wrap).
  - ramstore = store[g]; ramWEN = wen_q & req[g]; ramREN = ~wen_q & req[g].
  - FREE/BUSY: hold, rwait[g]=1.
  - ACCESS: rwait[g]=0 this cycle and word_cnt++. On the last word (word_cnt==len-1), go to RELEASE and advance pointer = (g+1) mod NUM_REQ.
  - ERROR: rerr[g]=1 for one cycle, rwait[g] stays 1, abort to RELEASE, advance pointer.
  - req[g] dropped mid-XFER: ram enables deassert the same cycle (combinational), go to IDLE next cycle, advance pointer, no error.
- RELEASE:
  - One cycle, enables 0, all rwait=1; lets the owner drop req before re-arbitration.
  - Then go to IDLE.
  - Back-to-back grants to the same requester are therefore at least 2 cycles apart.
- Non-owner rwait is always 1; wen/burst/addr changes of non-owners have no effect.
- Simultaneous requests: strict round-robin from the pointer; an owner never loses the grant mid-burst.
- Reset mid-transaction: immediate return to reset values, with no partial-burst completion.
- word_idx = word_cnt, 0 outside XFER.

Test Plan:
- Reset with req=2'b11 held: ramREN=ramWEN=0, grant=0, rwait=2'b11 while nRST low. After release, grant=2'b01 one cycle later.
- Requester 0 single read, addr=0x100, ACCESS on 3rd XFER cycle: ramaddr=0x100, ramREN=1 for 3 cycles, rwait[0]=0 exactly once, rload=ramload, then RELEASE, IDLE.
- Requester 1 burst write, addr=0x200, BLOCK_WORDS=2, ACCESS every cycle: ramaddr 0x200 then 0x204, ramWEN=1 both cycles, rwait[1] low 2 consecutive cycles, word_idx 0 then 1.
- Both requesting continuously, single reads: grants alternate 01,10,01,10 with 2-cycle IDLE/RELEASE gap; no starvation over 8 transactions.
- ramstate=ERROR during requester 0 burst word 1: rerr=2'b01 for one cycle, no second word issued, next grant goes to requester 1.
- Requester 0 drops req mid-burst after word 0: ramREN falls the same cycle, no rerr, arbiter back to IDLE next cycle, pointer=1.
